// File: rtl/stim_pkg.sv
// Shared types and default seeds for the xorshift128 stimulus generator.
package stim_pkg;

  localparam logic [31:0] DEF_SEED_X = 32'd123456789;
  localparam logic [31:0] DEF_SEED_Y = 32'd362436069;
  localparam logic [31:0] DEF_SEED_Z = 32'd521288629;
  localparam logic [31:0] DEF_SEED_W = 32'd1652613690;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PAT0 = 3'd1,
    PAT1 = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_e;

  // x occupies the top word so the packed vector reads {x, y, z, w}
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] w;
  } prng_t;

endpackage

// File: rtl/xorshift128_step.sv
// One combinational xorshift128 step (Marsaglia), all 32-bit modulo arithmetic.
module xorshift128_step
  import stim_pkg::*;
(
  input  prng_t state_i,
  output prng_t next_o
);

  logic [31:0] t_s;

  assign t_s      = state_i.x ^ (state_i.x << 11);
  assign next_o.x = state_i.y;
  assign next_o.y = state_i.z;
  assign next_o.z = state_i.w;
  assign next_o.w = state_i.w ^ (state_i.w >> 19) ^ t_s ^ (t_s >> 8);

endmodule

// File: rtl/xorshift_stim_gen.sv
// Stimulus generator: all-zeros word, all-ones word, then `count` xorshift128
// words over a valid/ready handshake.
module xorshift_stim_gen
  import stim_pkg::*;
#(
  parameter int          OUT_W  = 4,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] SEED_X = DEF_SEED_X,
  parameter logic [31:0] SEED_Y = DEF_SEED_Y,
  parameter logic [31:0] SEED_Z = DEF_SEED_Z,
  parameter logic [31:0] SEED_W = DEF_SEED_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] index
);

  localparam prng_t            SEED = '{x: SEED_X, y: SEED_Y, z: SEED_Z, w: SEED_W};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  prng_t            prng_q;
  prng_t            prng_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] index_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;

  logic             xfer_s;
  logic [127:0]     next_flat_s;
  logic [OUT_W-1:0] rand_word_s;
  logic [CNT_W-1:0] idx_inc_s;
  logic [CNT_W-1:0] cnt_m1_s;

  xorshift128_step u_step (
    .state_i (prng_q),
    .next_o  (prng_d)
  );

  assign xfer_s      = out_valid_q & out_ready;
  assign next_flat_s = prng_d;
  assign rand_word_s = next_flat_s[OUT_W-1:0];
  assign idx_inc_s   = index_q + ONE;
  assign cnt_m1_s    = cnt_q - ONE;

  // Sequencer: the PRNG and every output only move on a transfer or a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prng_q      <= SEED;
      cnt_q       <= '0;
      index_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= PAT0;
            prng_q      <= SEED;
            cnt_q       <= count;
            index_q     <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        PAT0: begin
          if (xfer_s) begin
            state_q    <= PAT1;
            out_data_q <= {OUT_W{1'b1}};
            out_last_q <= (cnt_q == '0);
          end
        end
        PAT1: begin
          if (xfer_s) begin
            if (cnt_q == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q    <= RUN;
              prng_q     <= prng_d;
              out_data_q <= rand_word_s;
              out_last_q <= (cnt_q == ONE);
            end
          end
        end
        RUN: begin
          // comparing against count-1 (never wrapping index) keeps count=max legal
          if (xfer_s) begin
            if (index_q == cnt_m1_s) begin
              state_q     <= DONE;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              prng_q     <= prng_d;
              index_q    <= idx_inc_s;
              out_data_q <= rand_word_s;
              out_last_q <= (idx_inc_s == cnt_m1_s);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign index     = index_q;

endmodule

// File: doc/xorshift_stim_gen.md
XORSHIFT_STIM_GEN -- requirements
Module: xorshift_stim_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- OUT_W, 4, stimulus word width, legal 1..128.
- CNT_W, 16, width of the random-word count.
- SEED_X, 123456789, PRNG x seed.
- SEED_Y, 362436069, PRNG y seed.
- SEED_Z, 521288629, PRNG z seed.
- SEED_W, 1652613690, PRNG w seed.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a sequence; sampled only in IDLE or DONE.
- count, in, CNT_W, number of random words; captured on start.
- out_ready, in, 1, consumer accepts out_data.
- out_valid, out, 1, out_data valid.
- out_data, out, OUT_W, stimulus word.
- out_last, out, 1, marks the final word of a sequence.
- busy, out, 1, high in PAT0, PAT1 and RUN.
- done, out, 1, high while in DONE.
- index, out, CNT_W, index of the current random word.

REQ-003 The block SHALL use one clock. Reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, PAT0, PAT1, RUN and DONE.
REQ-005 A transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-006 While out_valid=1 and out_ready=0, out_data, out_last and index SHALL hold stable.
REQ-007 In IDLE or DONE, start=1:
- PRNG state loads the SEED_* values.
- count is captured.
- index clears to 0.
- Next state is PAT0.
REQ-008 PAT0 SHALL drive out_valid=1 and out_data=0. On transfer it goes to PAT1.
REQ-009 PAT1 SHALL drive out_valid=1 and out_data all-ones.
REQ-010 On a PAT1 transfer:
- If count=0, next state is DONE.
- Otherwise the PRNG steps once, out_data loads the new word, and next state is RUN.
REQ-011 One PRNG step SHALL compute the following, all 32-bit modulo arithmetic:
- t = x ^ (x<<11)
- x' = y
- y' = z
- z' = w
- w' = w ^ (w>>19) ^ t ^ (t>>8)
REQ-012 The random word SHALL be the low OUT_W bits of {x',y',z',w'}.
REQ-013 On a RUN transfer:
- If index = count-1, next state is DONE and out_valid=0.
- Otherwise the PRNG steps, index increments, and out_data updates for the next cycle.
REQ-014 The first word of every phase SHALL be valid in the cycle after the state is entered. Back-to-back transfers SHALL run at one word per cycle with no bubbles.
REQ-015 out_last SHALL be 1 with the RUN word at index count-1. When count=0 it SHALL instead be 1 with the PAT1 word.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 start asserted in the same cycle as the final transfer SHALL be ignored. The block enters DONE and the next start restarts it.
REQ-018 index SHALL not wrap. count = 2^CNT_W-1 SHALL terminate at index 2^CNT_W-2.
REQ-019 The PRNG SHALL step only on a transfer and never while the consumer stalls.

Reset
REQ-020 rst_n=0 SHALL asynchronously force the following, from any state including mid-sequence:
- state = IDLE.
- out_valid = 0, out_data = 0, out_last = 0.
- busy = 0, done = 0, index = 0.
- PRNG state = SEED_*.
REQ-021 Deassertion SHALL take effect on a clk edge. No output SHALL change until a subsequent start.

Structure
REQ-022 Package stim_pkg SHALL hold:
- the four default seed constants,
- the FSM state enum,
- a 128-bit PRNG state struct.
REQ-023 The PRNG step SHALL be a combinational sub-module xorshift128_step (input 128-bit state, output 128-bit next state). It SHALL be instantiated once.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, start, count=3, out_ready=1, OUT_W=4: outputs 0000, then 1111, then three random words. The first random word is 1010. out_last is 1 only on the third random word. DONE follows.
- OUT_W=32, count=1: first random word = 0xBB6AB81A. out_last=1 on it.
- count=0: exactly two transfers (0, then all-ones). out_last=1 on the all-ones word.
- out_ready toggled pseudo-randomly with count=1000: the accepted sequence is identical to the out_ready=1 run. out_data is stable during stalls.
- rst_n pulsed low at index 5, then start again: the sequence restarts from pattern 0 and matches the first run bit-for-bit.
- start pulsed during RUN: no effect. start in DONE: repeats the identical sequence.
